// File: rtl/plic_arb_pkg.sv
// plic_arb_pkg: shared sizing helpers for the pipelined PLIC arbitration tree.
package plic_arb_pkg;
  localparam int FANIN = 4;
  function automatic int clog4(input int n);
    int l = 0;
    int p = 1;
    while (p < n) begin
      p = p * FANIN;
      l++;
    end
    return l;
  endfunction
  function automatic int pow4(input int l);
    return 1 << (2 * l);
  endfunction
  function automatic int pad_w(input int n);
    return pow4(clog4(n));
  endfunction
  // Flattened node entry layout, MSB first: {req, id[id_num], prio[prio_bit]}.
  function automatic int ent_w(input int id_num, input int prio_bit);
    return 1 + id_num + prio_bit;
  endfunction
  // Entry offset of level l inside the flat stage vector of a depth-lvl tree.
  function automatic int lvl_off(input int lvl, input int l);
    int o = 0;
    for (int k = 0; k < l; k++) o += pow4(lvl - 1 - k);
    return o;
  endfunction
endpackage

// File: rtl/plic_arb_node4.sv
// plic_arb_node4: combinational 4-way priority compare, lower index wins ties.
module plic_arb_node4 import plic_arb_pkg::*; #(
  parameter int ID_NUM = 7,
  parameter int PRIO_BIT = 5,
  localparam int EW = ent_w(ID_NUM, PRIO_BIT)
)(
  input  logic [4*EW-1:0] ent_i,
  output logic [EW-1:0]   ent_o
);
  logic [EW-1:0] lo, hi;
  function automatic logic [EW-1:0] pick(input logic [EW-1:0] l, input logic [EW-1:0] r);
    return (l[EW-1] && (!r[EW-1] || l[PRIO_BIT-1:0] >= r[PRIO_BIT-1:0])) ? l : r;
  endfunction
  assign lo    = pick(ent_i[0 +: EW], ent_i[EW +: EW]);
  assign hi    = pick(ent_i[2*EW +: EW], ent_i[3*EW +: EW]);
  assign ent_o = pick(lo, hi);
endmodule

// File: rtl/plic_arb_tree_pipe.sv
// plic_arb_tree_pipe: radix-4 pipelined priority tree, one register stage per level,
// with claim suppression of in-flight winners, flush, and an unpipelined threshold.
module plic_arb_tree_pipe import plic_arb_pkg::*; #(
  parameter int INT_NUM = 64,
  parameter int ID_NUM = 7,
  parameter int PRIO_BIT = 5
)(
  input  logic                        plic_clk,
  input  logic                        plicrst_b,
  input  logic [INT_NUM-1:0]          int_req,
  input  logic [INT_NUM*PRIO_BIT-1:0] int_prio,
  input  logic [PRIO_BIT-1:0]         int_thresh,
  input  logic                        arb_flush,
  input  logic                        claim_vld,
  input  logic [ID_NUM-1:0]           claim_id,
  output logic                        arb_out_vld,
  output logic                        arb_out_req,
  output logic [ID_NUM-1:0]           arb_out_id,
  output logic [PRIO_BIT-1:0]         arb_out_prio
);
  localparam int LVL = clog4(INT_NUM);
  localparam int PAD = pad_w(INT_NUM);
  localparam int EW  = ent_w(ID_NUM, PRIO_BIT);
  localparam int TOT = lvl_off(LVL, LVL);
  logic [PAD*EW-1:0] leaf;
  logic [TOT*EW-1:0] node_d, st_d, st_q;
  logic [LVL-1:0]    vld_q;
  logic [EW-1:0]     top_q;
  for (genvar i = 0; i < PAD; i++) begin : g_leaf
    if (i < INT_NUM) begin : g_src
      assign leaf[i*EW +: EW] = {int_req[i] && int_prio[i*PRIO_BIT +: PRIO_BIT] != '0,
                                 ID_NUM'(i), int_prio[i*PRIO_BIT +: PRIO_BIT]};
    end else begin : g_pad
      assign leaf[i*EW +: EW] = {1'b0, ID_NUM'(i), PRIO_BIT'(0)};
    end
  end
  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int N = pow4(LVL - 1 - l);
    localparam int O = lvl_off(LVL, l);
    for (genvar n = 0; n < N; n++) begin : g_node
      logic [4*EW-1:0] src;
      if (l == 0) begin : g_first
        assign src = leaf[n*4*EW +: 4*EW];
      end else begin : g_upper
        assign src = st_q[(lvl_off(LVL, l - 1) + 4*n)*EW +: 4*EW];
      end
      plic_arb_node4 #(.ID_NUM(ID_NUM), .PRIO_BIT(PRIO_BIT)) u_node (
        .ent_i(src),
        .ent_o(node_d[(O+n)*EW +: EW])
      );
    end
  end
  // A claimed id is dropped from whatever each stage loads at the claim edge.
  always_comb begin
    st_d = node_d;
    for (int k = 0; k < TOT; k++)
      if (claim_vld && node_d[k*EW+PRIO_BIT +: ID_NUM] == claim_id) st_d[k*EW+EW-1] = 1'b0;
  end
  always_ff @(posedge plic_clk) begin
    if (!plicrst_b || arb_flush) begin
      st_q  <= '0;
      vld_q <= '0;
    end else begin
      st_q  <= st_d;
      vld_q <= LVL'({vld_q, 1'b1});
    end
  end
  assign top_q        = st_q[(TOT-1)*EW +: EW];
  assign arb_out_vld  = vld_q[LVL-1];
  assign arb_out_req  = top_q[EW-1] && top_q[PRIO_BIT-1:0] > int_thresh;
  assign arb_out_id   = arb_out_req ? top_q[PRIO_BIT +: ID_NUM] : '0;
  assign arb_out_prio = arb_out_req ? top_q[PRIO_BIT-1:0] : '0;
endmodule

// File: tb/tb_plic_arb_tree_pipe.sv
// tb_plic_arb_tree_pipe: directed vector table plus hand sequences for latency,
// claim, flush, reset and padded-tree corners.
module tb_plic_arb_tree_pipe;
  localparam int N = 64, PB = 5, IW = 7;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush, cv;
  logic [N-1:0] req;
  logic [N*PB-1:0] prio;
  logic [PB-1:0] th;
  logic [IW-1:0] cid;
  logic o_vld, o_req;
  logic [IW-1:0] o_id;
  logic [PB-1:0] o_prio;
  logic [4:0] b_req;
  logic [5*PB-1:0] b_prio;
  logic b_vld, b_oreq;
  logic [IW-1:0] b_id;
  logic [PB-1:0] b_oprio;
  int total = 0, bad = 0;

  plic_arb_tree_pipe #(.INT_NUM(N), .ID_NUM(IW), .PRIO_BIT(PB)) dut (
    .plic_clk(clk), .plicrst_b(rst_n), .int_req(req), .int_prio(prio), .int_thresh(th),
    .arb_flush(flush), .claim_vld(cv), .claim_id(cid), .arb_out_vld(o_vld),
    .arb_out_req(o_req), .arb_out_id(o_id), .arb_out_prio(o_prio)
  );
  plic_arb_tree_pipe #(.INT_NUM(5), .ID_NUM(IW), .PRIO_BIT(PB)) dut5 (
    .plic_clk(clk), .plicrst_b(rst_n), .int_req(b_req), .int_prio(b_prio), .int_thresh(5'd0),
    .arb_flush(1'b0), .claim_vld(1'b0), .claim_id(7'd0), .arb_out_vld(b_vld),
    .arb_out_req(b_oreq), .arb_out_id(b_id), .arb_out_prio(b_oprio)
  );

  typedef struct {
    string name;
    int s0, p0, s1, p1, s2, p2;
    int th;
    int e_req, e_id, e_prio;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic src(input int i, input int p);
    req[i] = 1'b1;
    prio[i*PB +: PB] = PB'(p);
  endtask
  task automatic idle;
    req = '0;
    prio = '0;
  endtask
  task automatic chk_out(input string nm, input int r, input int id, input int p);
    chk({nm, "_req"}, int'(o_req), r);
    chk({nm, "_id"}, int'(o_id), id);
    chk({nm, "_prio"}, int'(o_prio), p);
  endtask

  initial begin
    v[0] = '{"tie3",     17, 7, 40, 7, 63, 7,  0, 1, 17, 7};
    v[1] = '{"raise63",  17, 7, 40, 7, 63, 8,  0, 1, 63, 8};
    v[2] = '{"th_eq",     5, 4, -1, 0, -1, 0,  4, 0,  0, 0};
    v[3] = '{"th_below",  5, 4, -1, 0, -1, 0,  3, 1,  5, 4};
    v[4] = '{"tie01",     0, 1,  1, 1, -1, 0,  0, 1,  0, 1};
    v[5] = '{"max_tie",  60, 31, 3, 31, -1, 0, 0, 1,  3, 31};
    v[6] = '{"prio0",     2, 0, -1, 0, -1, 0,  0, 0,  0, 0};
    v[7] = '{"hi_id",    62, 30, 10, 29, -1, 0, 0, 1, 62, 30};
    v[8] = '{"th_max",   20, 5, -1, 0, -1, 0, 31, 0,  0, 0};
    rst_n = 1'b0; flush = 1'b0; cv = 1'b0; cid = '0; th = '0;
    idle();
    b_req = '0; b_prio = '0;
    tick(); tick();
    chk("rst_vld", int'(o_vld), 0);
    chk_out("rst", 0, 0, 0);
    src(9, 3);
    rst_n = 1'b1;
    tick(); chk("fill1_vld", int'(o_vld), 0);
    tick(); chk("fill2_vld", int'(o_vld), 0);
    tick(); chk("fill3_vld", int'(o_vld), 1);
    chk_out("fill3", 1, 9, 3);

    for (int i = 0; i < 9; i++) begin
      idle();
      th = PB'(v[i].th);
      if (v[i].s0 >= 0) src(v[i].s0, v[i].p0);
      if (v[i].s1 >= 0) src(v[i].s1, v[i].p1);
      if (v[i].s2 >= 0) src(v[i].s2, v[i].p2);
      repeat (3) tick();
      chk_out(v[i].name, v[i].e_req, v[i].e_id, v[i].e_prio);
    end

    idle(); th = '0;
    src(17, 7); src(40, 7); src(63, 7);
    repeat (3) tick();
    src(63, 8);
    tick(); chk("lat1_id", int'(o_id), 17);
    tick(); chk("lat2_id", int'(o_id), 17);
    tick(); chk("lat3_id", int'(o_id), 63);

    idle(); src(5, 4); th = 5'd4;
    repeat (3) tick();
    chk("thr_hold_req", int'(o_req), 0);
    th = 5'd3;
    #1;
    chk_out("thr_comb", 1, 5, 4);

    idle(); th = '0; src(12, 6); src(30, 2);
    repeat (3) tick();
    chk("clm_pre_id", int'(o_id), 12);
    cv = 1'b1; cid = 7'd40;
    tick(); cv = 1'b0;
    tick(); chk("clm_miss1_id", int'(o_id), 12);
    tick(); chk("clm_miss2_id", int'(o_id), 12);
    cv = 1'b1; cid = 7'd12;
    tick();
    cv = 1'b0; req[12] = 1'b0;
    chk("clm_edge_no12", int'(o_req && o_id == 7'd12), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_out($sformatf("clm_p%0d", k), 1, 30, 2);
    end

    idle(); src(12, 6);
    repeat (3) tick();
    chk("fl_pre_vld", int'(o_vld), 1);
    flush = 1'b1;
    tick(); chk("fl1_vld", int'(o_vld), 0); chk("fl1_req", int'(o_req), 0);
    tick(); chk("fl2_vld", int'(o_vld), 0); chk("fl2_req", int'(o_req), 0);
    flush = 1'b0;
    tick(); chk("fl_r1_vld", int'(o_vld), 0);
    tick(); chk("fl_r2_vld", int'(o_vld), 0);
    tick(); chk("fl_r3_vld", int'(o_vld), 1);
    chk_out("fl_r3", 1, 12, 6);

    rst_n = 1'b0;
    tick(); chk("mrst_vld", int'(o_vld), 0); chk("mrst_req", int'(o_req), 0);
    rst_n = 1'b1;
    tick(); tick(); chk("mrst_r2_vld", int'(o_vld), 0);
    tick(); chk("mrst_r3_vld", int'(o_vld), 1);
    chk_out("mrst_r3", 1, 12, 6);

    b_req = 5'b10000;
    repeat (3) tick();
    chk("b_vld", int'(b_vld), 1);
    chk("b_prio0_req", int'(b_oreq), 0);
    b_prio[4*PB +: PB] = 5'd1;
    tick(); chk("b_lat1_req", int'(b_oreq), 0);
    tick(); chk("b_lat2_req", int'(b_oreq), 1);
    chk("b_lat2_id", int'(b_id), 4);
    chk("b_lat2_prio", int'(b_oprio), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/plic_arb_tree_pipe.md
# plic_arb_tree_pipe

Pipelined, parametrised priority arbiter for the PLIC gateway-to-hart path. It reduces INT_NUM pending interrupt sources to a single winner through a radix-4 comparison tree with one register stage per level. Stale in-flight winners are suppressed on claim or flush, and a per-target threshold gates the final output. It sits between the pending/enable array and the per-hart claim/EIP logic, and replaces the single-level combinational 4-way compare.

## Interface
- INT_NUM, 64: number of sources; any value ≥2; non-multiples of 4 are padded with req=0.
- ID_NUM, 7: id width; must satisfy 2^ID_NUM ≥ INT_NUM.
- PRIO_BIT, 5: priority width.
- LVL, derived = ceil(log4(INT_NUM)): tree depth, equal to pipeline latency.
- plic_clk  in  1  sole clock, all state on rising edge.
- plicrst_b  in  1  reset, synchronous, active-low.
- int_req  in  INT_NUM  pending & enabled, bit i = source id i.
- int_prio  in  INT_NUM*PRIO_BIT  priority of source i at [i*PRIO_BIT +: PRIO_BIT].
- int_thresh  in  PRIO_BIT  target threshold, sampled at the last stage.
- arb_flush  in  1  clears all stage valids and reqs.
- claim_vld  in  1  claim strobe, one cycle.
- claim_id  in  ID_NUM  id being claimed.
- arb_out_vld  out  1  pipeline filled since last reset/flush.
- arb_out_req  out  1  winner exists and its prio > int_thresh.
- arb_out_id  out  ID_NUM  winner id, 0 when !arb_out_req.
- arb_out_prio  out  PRIO_BIT  winner prio, 0 when !arb_out_req.

## Operation
- Leaf: source i contributes (req_i && prio_i != 0, id=i, prio_i). Priority 0 never wins.
- Each node is a 4-way compare with the same semantics as the existing granule:
  - pair (0,1) then (2,3) then final;
  - a requesting left side wins when its prio ≥ the right side's prio;
  - net effect: equal priorities resolve to the lowest id.
- Each level is registered. A stage entry holds {req, id, prio} for each node, plus one stage valid bit.
- Stage valid shifts in 1 every cycle. After reset or flush, arb_out_vld rises after LVL cycles.
- Claim suppression:
  - When claim_vld=1, every stage entry (all levels, all nodes) whose id == claim_id and req=1 has its req cleared at that edge. The entry loaded on the same edge is cleared too.
  - This prevents a just-claimed id from re-presenting during the LVL-cycle latency.
  - The upstream pending bit is expected to drop within 1 cycle of claim.
- Threshold: arb_out_req = last_req && (last_prio > int_thresh). int_thresh is applied combinationally on the final register and is not pipelined, so threshold changes take effect in 0 cycles.
- Flush has priority over claim. Both have priority over normal load.
- Reset values: all stage req/valid = 0, arb_out_vld=0, arb_out_req=0, arb_out_id=0, arb_out_prio=0.

## Timing
- Latency: a req/prio change at cycle t is reflected at the output at t+LVL. There are no bubbles, and throughput is 1 result per cycle.
- Output id/prio are masked to 0 whenever arb_out_req=0.
- Reset mid-operation: reset takes effect at the next edge with plicrst_b=0, and all state clears. Re-fill takes LVL cycles after release.
- Flush behaves like reset but is a functional input. A flush asserted for N cycles keeps arb_out_vld=0 until LVL cycles after its last asserted cycle.
- Claim and change on the same cycle:
  - A claim of an id that is not in flight has no effect.
  - A claim of an id present in two levels clears both.
- INT_NUM=4 gives LVL=1, a single registered granule. INT_NUM=5 gives LVL=2, with ids 5..15 padded.

## Structure
- Shared package plic_arb_pkg:
  - function clog4(n);
  - localparam-style helpers for padded width (4^LVL);
  - node entry struct {req, id[ID_NUM], prio[PRIO_BIT]} as a flattened-vector width constant.
- One sub-module, plic_arb_node4: a combinational 4-way compare with no id inputs generated internally. The top generates LVL levels of nodes, the stage registers, and the claim/flush masks.

## Test plan
- Reset/fill: INT_NUM=64, only src 9 req prio 3, thresh 0, release reset → arb_out_vld=0 for 3 cycles, then req=1, id=9, prio=3.
- Tie-break: srcs 17, 40, 63 all prio 7 → id=17. Raise src 63 to prio 8 → id=63 exactly 3 cycles later.
- Threshold: src 5 prio 4, thresh 4 → req=0, id=0, prio=0. Thresh→3 → req=1, id=5 on the same cycle.
- Claim suppression: src 12 prio 6, src 30 prio 2 steady. Claim_id=12 pulse with src 12 req dropped the next cycle → output never shows 12 after the claim edge and shows 30 from claim+1.
- Flush: active traffic, arb_flush held 2 cycles → arb_out_vld=0, arb_out_req=0 from the first flush edge, and valid returns 3 cycles after the flush drops.
- Prio-0 and padding: INT_NUM=5, src 4 prio 0 req=1, others idle → req=0. Set src 4 prio 1 → id=4 after 2 cycles.
